// File: rtl/ext_sram_mc.sv
// ext_sram_mc: one write channel and NUM_RD read channels sharing a single-port word array, with arbitration, a fixed read latency and optional stall injection
module ext_sram_mc #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int DEPTH = 1 << ADDR_W,
  parameter int NUM_RD = 2,
  parameter int RD_LAT = 2,
  parameter int WR_PRIO = 1,
  parameter int STALL_EN = 0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic [DATA_W/8-1:0]      w_strb,
  input  logic [NUM_RD-1:0]        r_valid,
  output logic [NUM_RD-1:0]        r_ready,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD-1:0]        r_dvalid,
  output logic [NUM_RD*DATA_W-1:0] r_data
);
  localparam int NS = NUM_RD + 1;
  localparam int PW = $clog2(NS);
  localparam int IW = $clog2(DEPTH);
  localparam int PL = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [PW-1:0] ptr, win, lch;
  logic [PW:0] sum;
  logic [15:0] lfsr;
  logic [2*NS-1:0] dbl;
  logic found, gnt, rd_sel, lv;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word, ld;
  logic [RD_LAT-1:0] pv;
  logic [PW-1:0] pch [RD_LAT];
  logic [DATA_W-1:0] pd [PL];
  // The request vector is doubled so a plain shift by the pointer gives the rotated search order
  always_comb begin
    dbl = {2{(WR_PRIO != 0) ? {1'b0, r_valid} : {w_valid, r_valid}}} >> ptr;
    sum = '0;
    found = 1'b0;
    for (int k = NS - 1; k >= 0; k--)
      if (dbl[k]) begin
        found = 1'b1;
        sum = {1'b0, ptr} + (PW+1)'(k);
      end
    win = (sum >= (PW+1)'(NS)) ? PW'(sum - (PW+1)'(NS)) : PW'(sum);
    if (WR_PRIO != 0 && w_valid) begin
      win = PW'(NUM_RD);
      found = 1'b1;
    end
    gnt = !rst && found && !(STALL_EN != 0 && lfsr[0]);
    w_ready = gnt && win == PW'(NUM_RD);
    rd_sel = gnt && !w_ready;
    r_ready = '0;
    rd_addr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      r_ready[i] = gnt && win == PW'(i);
      if (win == PW'(i)) rd_addr = r_addr[i*ADDR_W +: ADDR_W];
    end
    rd_word = (64'(rd_addr) < 64'(DEPTH)) ? ram[rd_addr[IW-1:0]] : '0;
  end
  assign lv = (RD_LAT == 1) ? rd_sel : pv[PL-1];
  assign lch = (RD_LAT == 1) ? win : pch[PL-1];
  assign ld = (RD_LAT == 1) ? rd_word : pd[PL-1];
  always_comb begin
    r_dvalid = '0;
    for (int i = 0; i < NUM_RD; i++) r_dvalid[i] = pv[RD_LAT-1] && pch[RD_LAT-1] == PW'(i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      lfsr <= STALL_SEED;
      pv <= '0;
      r_data <= '0;
      for (int k = 0; k < RD_LAT; k++) pch[k] <= '0;
      for (int k = 0; k < PL; k++) pd[k] <= '0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (gnt) ptr <= (win == PW'(NS - 1)) ? '0 : win + 1'b1;
      pv[0] <= rd_sel;
      pch[0] <= win;
      pd[0] <= rd_word;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        pch[k] <= pch[k-1];
      end
      for (int k = 1; k < PL; k++) pd[k] <= pd[k-1];
      for (int i = 0; i < NUM_RD; i++)
        if (lv && lch == PW'(i)) r_data[i*DATA_W +: DATA_W] <= ld;
    end
  end
  // Array contents survive reset so a preload or earlier writes stay visible
  always_ff @(posedge clk)
    if (w_ready && 64'(w_addr) < 64'(DEPTH))
      for (int b = 0; b < DATA_W / 8; b++)
        if (w_strb[b]) ram[w_addr[IW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
endmodule

// File: tb/tb_ext_sram_mc.sv
// tb_ext_sram_mc: directed checks of ext_sram_mc over four parameter sets sharing one stimulus bus
module tb_ext_sram_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w_valid = 1'b0;
  logic [4:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0] w_strb = '0;
  logic [1:0] r_valid = '0;
  logic [9:0] r_addr = '0;
  logic w_ready_a, w_ready_b, w_ready_c, w_ready_d;
  logic [1:0] r_ready_a, r_ready_b, r_ready_c, r_ready_d;
  logic [1:0] r_dvalid_a, r_dvalid_b, r_dvalid_c, r_dvalid_d;
  logic [63:0] r_data_a, r_data_b, r_data_c, r_data_d;
  logic [15:0] lfsr_m;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ext_sram_mc #(.ADDR_W(5), .DEPTH(16), .NUM_RD(2), .RD_LAT(2), .WR_PRIO(1), .STALL_EN(0)) u_a (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_a), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .r_valid(r_valid), .r_ready(r_ready_a), .r_addr(r_addr), .r_dvalid(r_dvalid_a),
    .r_data(r_data_a));
  ext_sram_mc #(.ADDR_W(5), .DEPTH(16), .NUM_RD(2), .RD_LAT(2), .WR_PRIO(0), .STALL_EN(0)) u_b (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_b), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .r_valid(r_valid), .r_ready(r_ready_b), .r_addr(r_addr), .r_dvalid(r_dvalid_b),
    .r_data(r_data_b));
  ext_sram_mc #(.ADDR_W(5), .DEPTH(16), .NUM_RD(2), .RD_LAT(2), .WR_PRIO(1), .STALL_EN(1),
                .STALL_SEED(16'hACE1)) u_c (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_c), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .r_valid(r_valid), .r_ready(r_ready_c), .r_addr(r_addr), .r_dvalid(r_dvalid_c),
    .r_data(r_data_c));
  ext_sram_mc #(.ADDR_W(5), .DEPTH(16), .NUM_RD(2), .RD_LAT(3), .WR_PRIO(1), .STALL_EN(0)) u_d (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_d), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .r_valid(r_valid), .r_ready(r_ready_d), .r_addr(r_addr), .r_dvalid(r_dvalid_d),
    .r_data(r_data_d));

  // Reference x^16+x^14+x^13+x^11 sequence, right-shifting with the feedback entering bit 15
  always @(posedge clk or posedge rst)
    if (rst) lfsr_m <= 16'hACE1;
    else lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
    @(negedge clk);
    w_valid = 1'b1; w_addr = a; w_data = d; w_strb = s; ok = 1'b0;
    repeat (20) if (!ok) begin #1; ok = w_ready_a; if (!ok) @(negedge clk); end
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic rd(input bit on_d, input bit ch, input logic [4:0] a, output logic [31:0] d, output int lat);
    bit g;
    @(negedge clk);
    r_valid[ch] = 1'b1;
    if (ch) r_addr[9:5] = a; else r_addr[4:0] = a;
    g = 1'b0; lat = -1; d = '0;
    repeat (20) if (!g) begin
      #1;
      g = on_d ? r_ready_d[ch] : r_ready_a[ch];
      if (!g) @(negedge clk);
    end
    @(negedge clk);
    r_valid[ch] = 1'b0;
    if (g) for (int i = 1; i <= 8 && lat < 0; i++) begin
      if (on_d ? r_dvalid_d[ch] : r_dvalid_a[ch]) begin
        lat = i;
        d = on_d ? (ch ? r_data_d[63:32] : r_data_d[31:0]) : (ch ? r_data_a[63:32] : r_data_a[31:0]);
      end else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    w_valid = 1'b1; r_valid = 2'b11;
    #2;
    n_chk++; if ({w_ready_a, r_ready_a} !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", {w_ready_a, r_ready_a}); end
    w_valid = 1'b0; r_valid = 2'b00;
    repeat (2) @(negedge clk);
    n_chk++; if (r_dvalid_a !== 2'b00) begin n_fail++; $display("FAIL reset_dvalid got %b want 00", r_dvalid_a); end
    n_chk++; if (r_data_a !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", r_data_a); end
    n_chk++; if ({r_dvalid_d, r_data_d} !== 66'h0) begin n_fail++; $display("FAIL reset_d got %h want 0", {r_dvalid_d, r_data_d}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] d; int lat;
    @(negedge clk);
    w_valid = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF; w_strb = 4'hF;
    #1;
    n_chk++; if (w_ready_a !== 1'b1) begin n_fail++; $display("FAIL wr_first_ready got %b want 1", w_ready_a); end
    @(negedge clk);
    w_valid = 1'b0;
    rd(1'b0, 1'b0, 5'd5, d, lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL rd_latency got %0d want 2", lat); end
    n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data ch0 got %h want deadbeef", d); end
    @(negedge clk);
    n_chk++; if (r_dvalid_a !== 2'b00) begin n_fail++; $display("FAIL dvalid_single got %b want 00", r_dvalid_a); end
    rd(1'b0, 1'b1, 5'd5, d, lat);
    n_chk++; if (lat != 2 || d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data ch1 got %h lat %0d want deadbeef lat 2", d, lat); end
  endtask

  task automatic test_strobes();
    bit ok; logic [31:0] d; int lat;
    wr_a(5'd7, 32'h11223344, 4'hF, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL strb_wr1 got no grant want grant"); end
    wr_a(5'd7, 32'hAABBCCDD, 4'b0101, ok);
    rd(1'b0, 1'b1, 5'd7, d, lat);
    n_chk++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb_merge got %h want 11bb33dd", d); end
  endtask

  task automatic test_arb_prio();
    logic [14:0] seq;
    seq = {3'b100, 3'b001, 3'b010, 3'b001, 3'b010};
    @(negedge clk);
    w_valid = 1'b1; w_addr = 5'd9; w_data = 32'h99; w_strb = 4'hF; r_valid = 2'b11; r_addr = {5'd1, 5'd2};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if ({w_ready_a, r_ready_a} !== seq[14-3*i -: 3]) begin n_fail++; $display("FAIL arb_prio step %0d got %b want %b", i, {w_ready_a, r_ready_a}, seq[14-3*i -: 3]); end
      @(negedge clk);
      if (i == 0) w_valid = 1'b0;
    end
    r_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_arb_rr();
    logic [17:0] seq;
    seq = {3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    @(negedge clk);
    w_valid = 1'b1; w_addr = 5'd20; w_data = 32'h77; w_strb = 4'hF; r_valid = 2'b00;
    #1;
    n_chk++; if ({w_ready_b, r_ready_b} !== 3'b100) begin n_fail++; $display("FAIL rr_prime got %b want 100", {w_ready_b, r_ready_b}); end
    @(negedge clk);
    r_valid = 2'b11; r_addr = {5'd3, 5'd4};
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++; if ({w_ready_b, r_ready_b} !== seq[17-3*i -: 3]) begin n_fail++; $display("FAIL arb_rr step %0d got %b want %b", i, {w_ready_b, r_ready_b}, seq[17-3*i -: 3]); end
      @(negedge clk);
    end
    w_valid = 1'b0; r_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    int cnt, exp_cnt; bit e;
    cnt = 0; exp_cnt = 0;
    @(negedge clk);
    w_valid = 1'b0; r_valid = 2'b01; r_addr[4:0] = 5'd3;
    repeat (200) begin
      #1;
      e = !lfsr_m[0];
      exp_cnt += int'(e);
      cnt += int'(r_ready_c[0]);
      n_chk++; if ({w_ready_c, r_ready_c} !== {2'b00, e}) begin n_fail++; $display("FAIL stall_gnt lfsr %h got %b want %b", lfsr_m, {w_ready_c, r_ready_c}, {2'b00, e}); end
      @(negedge clk);
    end
    r_valid = 2'b00;
    repeat (3) begin
      #1;
      n_chk++; if ({w_ready_c, r_ready_c} !== 3'b000) begin n_fail++; $display("FAIL stall_idle got %b want 000", {w_ready_c, r_ready_c}); end
      @(negedge clk);
    end
    n_chk++; if (cnt != exp_cnt) begin n_fail++; $display("FAIL stall_count got %0d want %0d", cnt, exp_cnt); end
  endtask

  task automatic test_oor();
    bit ok; logic [31:0] d; int lat;
    for (int i = 0; i < 16; i++) wr_a(5'(i), 32'h5A000000 + 32'(i), 4'hF, ok);
    wr_a(5'd20, 32'hCAFEF00D, 4'hF, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL oor_wr_hs got no grant want grant"); end
    rd(1'b0, 1'b0, 5'd20, d, lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL oor_rd_hs got lat %0d want 2", lat); end
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data got %h want 0", d); end
    for (int i = 0; i < 16; i++) begin
      rd(1'b0, i[0], 5'(i), d, lat);
      n_chk++; if (d !== 32'h5A000000 + 32'(i)) begin n_fail++; $display("FAIL oor_keep addr %0d got %h want %h", i, d, 32'h5A000000 + 32'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    bit g, seen; logic [31:0] d; int lat;
    @(negedge clk);
    r_valid = 2'b10; r_addr[9:5] = 5'd3; g = 1'b0; seen = 1'b0;
    repeat (20) if (!g) begin #1; g = r_ready_d[1]; if (!g) @(negedge clk); end
    n_chk++; if (!g) begin n_fail++; $display("FAIL mid_grant got no grant want grant"); end
    @(negedge clk);
    r_valid = 2'b00; rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (r_dvalid_d !== 2'b00) seen = 1'b1;
      @(negedge clk);
      if (i == 0) rst = 1'b0;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_flush got dvalid want none"); end
    n_chk++; if (r_data_d !== 64'h0) begin n_fail++; $display("FAIL mid_data got %h want 0", r_data_d); end
    rd(1'b1, 1'b1, 5'd3, d, lat);
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL mid_lat got %0d want 3", lat); end
    n_chk++; if (d !== 32'h5A000003) begin n_fail++; $display("FAIL mid_keep got %h want 5a000003", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_arb_prio();
    test_arb_rr();
    test_stall();
    test_oor();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
